dmem_sram_ctrl: RTL and testbench

Data-memory responder for the five-stage ARM pipeline. It accepts MEM_R/MEM_W requests from the EXE/MEM boundary and performs each 32-bit access as two 16-bit accesses on an external asynchronous SRAM. While an access is in flight it holds `ready` low, and the pipeline freezes. It returns read data to the MEM stage, which forwards it to MEM_REG/WB.

---
 rtl/arm_pkg.sv | 16 +
 rtl/sram_phase_cnt.sv | 29 ++
 rtl/dmem_sram_ctrl.sv | 117 +++++++++++
 tb/tb_dmem_sram_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline data-memory path.
// Holds the SRAM responder state encoding and SRAM geometry.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } dmem_state_t;

  localparam int DMEM_BASE_DEF = 1024;
  localparam int SRAM_AW       = 18;
  localparam int SRAM_DW       = 16;

endpackage

// File: rtl/sram_phase_cnt.sv
// Wait-state counter for one 16-bit SRAM phase.
// Flags the final count and the one before it.
module sram_phase_cnt #(
  parameter int WAIT_CYCLES = 5,
  parameter int CW          = $clog2(WAIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          pre_last
);

  assign last     = (cnt == CW'(WAIT_CYCLES - 1));
  assign pre_last = (cnt == CW'(WAIT_CYCLES - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// Data-memory responder: each 32-bit access becomes two
// 16-bit asynchronous SRAM phases, low half first.
module dmem_sram_ctrl
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int DMEM_BASE   = DMEM_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R,
  input  logic               MEM_W,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        data_mem,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int CW = $clog2(WAIT_CYCLES);

  dmem_state_t   state;
  logic [16:0]   widx;
  logic [31:0]   wdata;
  logic          wr;
  logic [31:0]   eff;
  logic          req;
  logic          cnt_en;
  logic          cnt_clr;
  logic          last;
  logic          pre_last;
  logic [CW-1:0] cnt;
  logic          unused_ok;

  assign eff       = ALU_res - 32'(DMEM_BASE);
  assign unused_ok = ^{eff[31:19], eff[1:0], cnt};
  assign req       = MEM_R | MEM_W;
  assign ready     = ((state == IDLE) & ~req) | (state == DONE);
  assign cnt_en    = (state == LOW) | (state == HIGH);
  assign cnt_clr   = ~cnt_en | last;

  sram_phase_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .CW         (CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt),
    .last    (last),
    .pre_last(pre_last)
  );

  // Outputs are set one edge ahead so they are stable for the
  // whole cycle they apply to; we_n rises for the last count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      widx        <= '0;
      wdata       <= '0;
      wr          <= 1'b0;
      data_mem    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            widx        <= eff[18:2];
            wdata       <= val_rm;
            wr          <= MEM_W;
            sram_addr   <= {eff[18:2], 1'b0};
            sram_dq_out <= val_rm[15:0];
            sram_dq_oe  <= MEM_W;
            sram_we_n   <= ~MEM_W;
            state       <= LOW;
          end
        end
        LOW: begin
          if (last) begin
            if (!wr) data_mem[15:0] <= sram_dq_in;
            sram_addr   <= {widx, 1'b1};
            sram_dq_out <= wdata[31:16];
            sram_we_n   <= ~wr;
            state       <= HIGH;
          end else if (pre_last) begin
            sram_we_n <= 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            if (!wr) data_mem[31:16] <= sram_dq_in;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            state      <= DONE;
          end else if (pre_last) begin
            sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Self-checking bench for dmem_sram_ctrl with an SRAM model
// and a word-level reference memory.
module tb_dmem_sram_ctrl;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_R = 1'b0;
  logic        MEM_W = 1'b0;
  logic [31:0] ALU_res = '0;
  logic [31:0] val_rm = '0;
  logic [31:0] data_mem;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  bit   [15:0] sram [0:262143];
  bit   [31:0] ref_mem [int];
  logic [31:0] exp_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;

  dmem_sram_ctrl #(
    .WAIT_CYCLES(W),
    .DMEM_BASE  (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R      (MEM_R),
    .MEM_W      (MEM_W),
    .ALU_res    (ALU_res),
    .val_rm     (val_rm),
    .data_mem   (data_mem),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign sram_dq_in = sram[sram_addr];

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] e;
    e = a - BASE;
    return int'((e / 4) % 32'h20000);
  endfunction

  function automatic logic [31:0] ref_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    ref_mem[i]   = v;
    sram[2*i]    = v[15:0];
    sram[2*i+1]  = v[31:16];
  endtask

  // Drives one request, follows it to the ready pulse, then drops it.
  task automatic access(input bit w, input bit r,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input bit b2b);
    int busy = 0, lo_oe = 0, hi_oe = 0;
    int lo_we = 0, hi_we = 0, any_oe = 0;
    bit done = 0;
    int i;
    logic [17:0] lo, hi;
    i  = widx(a);
    lo = 18'(i * 2);
    hi = 18'(i * 2 + 1);
    MEM_W = w; MEM_R = r; ALU_res = a; val_rm = wd;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!ready) busy++;
      else done = 1;
      if (sram_dq_oe) begin
        any_oe++;
        if (sram_addr == lo && sram_dq_out == wd[15:0])  lo_oe++;
        if (sram_addr == hi && sram_dq_out == wd[31:16]) hi_oe++;
      end
      if (!sram_we_n) begin
        if (sram_addr == lo) lo_we++;
        if (sram_addr == hi) hi_we++;
      end
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_cycles", busy, 2*W+1);
    if (b2b) check("b2b_gap", cyc - last_done, 2*W+2);
    last_done = cyc;
    if (w) begin
      ref_mem[i] = wd;
      check("wr_lo_oe", lo_oe, W);
      check("wr_hi_oe", hi_oe, W);
      check("wr_lo_we", lo_we, W-1);
      check("wr_hi_we", hi_we, W-1);
      check("sram_word", {sram[hi], sram[lo]}, wd);
    end else begin
      exp_data = ref_rd(i);
      check("rd_oe", any_oe, 0);
    end
    check("data_mem", data_mem, exp_data);
    @(posedge clk);
    #1;
    MEM_R = 1'b0;
    MEM_W = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    bit op_w, op_r;

    preload(0, 32'hDEADBEEF);
    for (int i = 1; i < 64; i++) preload(i, $urandom);
    preload(32'h1FFFF, $urandom);

    for (int k = 0; k < 4; k++) begin
      MEM_R = 1'($urandom); MEM_W = 1'($urandom);
      ALU_res = $urandom; val_rm = $urandom;
      @(negedge clk);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_data", data_mem, 32'h0);
      check("rst_ready", 32'(ready), 32'(!(MEM_R | MEM_W)));
    end
    MEM_R = 1'b0; MEM_W = 1'b0;
    #1;
    check("rst_ready_idle", 32'(ready), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    access(0, 1, BASE, 32'h0, 0);
    check("rd_deadbeef", data_mem, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("idle_hold", data_mem, 32'hDEADBEEF);
    access(1, 0, BASE + 4, 32'h12345678, 0);
    check("wr_keeps_data", data_mem, 32'hDEADBEEF);

    @(posedge clk); #1;
    access(1, 0, BASE + 8, 32'hCAFEF00D, 0);
    access(0, 1, BASE + 8, 32'h0, 1);
    check("b2b_readback", data_mem, 32'hCAFEF00D);

    access(1, 1, BASE + 12, 32'hA5A55A5A, 1);
    check("rw_is_write", data_mem, 32'hCAFEF00D);
    access(0, 1, BASE + 12, 32'h0, 1);

    access(1, 0, BASE - 4, 32'h0BADF00D, 0);
    access(0, 1, BASE - 4, 32'h0, 1);
    check("wrap_readback", data_mem, 32'h0BADF00D);

    for (int k = 0; k < 16; k++) begin
      op_w = 1'($urandom);
      op_r = op_w ? 1'($urandom) : 1'b1;
      v = BASE + 32'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        access(op_w, op_r, v, $urandom, 0);
      end else begin
        access(op_w, op_r, v, $urandom, 1);
      end
    end

    @(posedge clk); #1;
    MEM_R = 1'b1; ALU_res = BASE + 16;
    repeat (W + 3) @(negedge clk);
    #2;
    rst = 1'b0;
    MEM_R = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_data", data_mem, 32'h0);
    check("abort_addr", 32'(sram_addr), 32'd0);
    check("abort_dq", 32'(sram_dq_out), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    exp_data = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(0, 1, BASE + 16, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
